// File: rtl/acc_control_unit.sv
// Multicycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Owns PC, IR, OPR, ACC and flags; drives the external ALU and the 256-byte memory.
module acc_control_unit #(
  parameter logic [7:0] RESET_PC        = 8'h00,
  parameter bit         HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  output logic [7:0] mem_addr_o,
  input  logic [7:0] mem_rdata_i,
  output logic [7:0] mem_wdata_o,
  output logic       mem_we_o,
  output logic [7:0] alu_x_o,
  output logic [7:0] alu_y_o,
  output logic [2:0] alu_op_o,
  input  logic [7:0] alu_r_i,
  input  logic [1:0] alu_flags_i,
  output logic [7:0] acc_o,
  output logic [1:0] flags_o,
  output logic [7:0] pc_o,
  output logic       halted_o,
  output logic       retire_o
);

  localparam int unsigned DW = 8;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_LDA = 3'b010;
  localparam logic [2:0] ALU_LDI = 3'b111;

  typedef enum logic [3:0] {
    S_F1, S_F2, S_A1, S_A2, S_EXI, S_M1, S_EX, S_ST, S_HALT
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   pc, pc_d, opr, opr_d, acc, acc_d;
  logic [3:0]      ir_op, ir_op_d;
  logic [1:0]      flags, flags_d;
  logic [DW-1:0]   pc_inc;
  logic [3:0]      fetch_op;
  logic            fetch_illegal;

  assign pc_inc        = DW'(pc + DW'(1));
  assign fetch_op      = mem_rdata_i[7:4];
  assign fetch_illegal = (fetch_op >= 4'h9) && (fetch_op <= 4'hE);

  assign mem_wdata_o = acc;
  assign alu_x_o     = acc;
  assign acc_o       = acc;
  assign flags_o     = flags;
  assign pc_o        = pc;

  // State register and datapath registers; reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= S_F1;
      pc    <= RESET_PC;
      ir_op <= '0;
      opr   <= '0;
      acc   <= '0;
      flags <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      ir_op <= ir_op_d;
      opr   <= opr_d;
      acc   <= acc_d;
      flags <= flags_d;
    end
  end

  // Next-state, datapath next values and per-state outputs.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    ir_op_d    = ir_op;
    opr_d      = opr;
    acc_d      = acc;
    flags_d    = flags;
    mem_addr_o = pc;
    mem_we_o   = 1'b0;
    alu_y_o    = '0;
    alu_op_o   = ALU_LDA;
    retire_o   = 1'b0;
    halted_o   = 1'b0;
    unique case (state)
      S_F1: state_d = S_F2;
      S_F2: begin
        ir_op_d = fetch_op;
        pc_d    = pc_inc;
        if (fetch_op == OP_NOP || (fetch_illegal && !HALT_ON_ILLEGAL)) begin
          retire_o = 1'b1;
          state_d  = S_F1;
        end else if (fetch_op == OP_HLT || fetch_illegal) begin
          retire_o = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_A1;
        end
      end
      S_A1: state_d = S_A2;
      S_A2: begin
        opr_d = mem_rdata_i;
        pc_d  = pc_inc;
        case (ir_op)
          OP_LDI:                 state_d = S_EXI;
          OP_LDA, OP_ADD, OP_SUB: state_d = S_M1;
          OP_STA:                 state_d = S_ST;
          default: begin
            // Jumps: a taken branch replaces the operand-fetch increment.
            if (ir_op == OP_JMP || (ir_op == OP_JZ && flags[0]) ||
                (ir_op == OP_JC && flags[1]))
              pc_d = mem_rdata_i;
            retire_o = 1'b1;
            state_d  = S_F1;
          end
        endcase
      end
      S_EXI: begin
        alu_op_o   = ALU_LDI;
        alu_y_o    = opr;
        acc_d      = alu_r_i;
        flags_d[0] = alu_flags_i[0];
        retire_o   = 1'b1;
        state_d    = S_F1;
      end
      S_M1: begin
        mem_addr_o = opr;
        state_d    = S_EX;
      end
      S_EX: begin
        alu_y_o = mem_rdata_i;
        case (ir_op)
          OP_ADD:  alu_op_o = ALU_ADD;
          OP_SUB:  alu_op_o = ALU_SUB;
          default: alu_op_o = ALU_LDA;
        endcase
        acc_d      = alu_r_i;
        flags_d[0] = alu_flags_i[0];
        if (ir_op == OP_ADD || ir_op == OP_SUB)
          flags_d[1] = alu_flags_i[1];
        retire_o = 1'b1;
        state_d  = S_F1;
      end
      S_ST: begin
        mem_addr_o = opr;
        // A store coinciding with reset must not reach memory.
        mem_we_o   = !reset_i;
        retire_o   = 1'b1;
        state_d    = S_F1;
      end
      S_HALT: halted_o = 1'b1;
      default: state_d = S_F1;
    endcase
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// Self-checking bench for acc_control_unit: memory and ALU models plus a retire scoreboard.
module tb_acc_control_unit;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] mem_addr, mem_rdata, mem_wdata, alu_x, alu_y, alu_r, acc, pc;
  logic [2:0] alu_op;
  logic [1:0] alu_flags, flags;
  logic       mem_we, halted, retire;

  logic [7:0] mem_addr_h, mem_rdata_h, mem_wdata_h, alu_x_h, alu_y_h, alu_r_h, acc_h, pc_h;
  logic [2:0] alu_op_h;
  logic [1:0] alu_flags_h, flags_h;
  logic       mem_we_h, halted_h, retire_h;

  logic [7:0] mem [256];
  logic [7:0] mem_h [256];
  int         we_cnt;
  logic [7:0] we_addr, we_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] acc;
    logic [1:0] flags;
    logic [7:0] pc;
    int         lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  acc_control_unit #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b0)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .mem_wdata_o(mem_wdata), .mem_we_o(mem_we), .alu_x_o(alu_x), .alu_y_o(alu_y),
    .alu_op_o(alu_op), .alu_r_i(alu_r), .alu_flags_i(alu_flags), .acc_o(acc),
    .flags_o(flags), .pc_o(pc), .halted_o(halted), .retire_o(retire)
  );

  acc_control_unit #(.RESET_PC(8'h00), .HALT_ON_ILLEGAL(1'b1)) u_dut_h (
    .clk_i(clk), .reset_i(reset_i), .mem_addr_o(mem_addr_h), .mem_rdata_i(mem_rdata_h),
    .mem_wdata_o(mem_wdata_h), .mem_we_o(mem_we_h), .alu_x_o(alu_x_h), .alu_y_o(alu_y_h),
    .alu_op_o(alu_op_h), .alu_r_i(alu_r_h), .alu_flags_i(alu_flags_h), .acc_o(acc_h),
    .flags_o(flags_h), .pc_o(pc_h), .halted_o(halted_h), .retire_o(retire_h)
  );

  // Reference ALU: returns {fc, fz, result}.
  function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] x,
                                       input logic [7:0] y);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    case (op)
      3'b000: begin s = {1'b0, x} + {1'b0, y}; r = s[7:0]; c = s[8]; end
      3'b001: begin r = x - y; c = (x < y); end
      default: begin r = y; c = 1'b0; end
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  assign {alu_flags[1], alu_flags[0], alu_r}       = alu_f(alu_op, alu_x, alu_y);
  assign {alu_flags_h[1], alu_flags_h[0], alu_r_h} = alu_f(alu_op_h, alu_x_h, alu_y_h);

  always @(posedge clk) begin
    mem_rdata   <= mem[mem_addr];
    mem_rdata_h <= mem_h[mem_addr_h];
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_prog();
    reset_i = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    we_cnt = 0;
    sb.delete();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [1:0] f, input logic [7:0] p,
                      input int lat);
    exp_t e;
    e.acc = a; e.flags = f; e.pc = p; e.lat = lat;
    sb.push_back(e);
  endtask

  // Wait for each retire, check its latency, then the committed state.
  task automatic run_retires(input int k);
    exp_t e;
    int   n;
    for (int i = 0; i < k; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!retire && n < 20);
      check("retire_seen", retire, 1);
      e = sb.pop_front();
      check("latency", n, e.lat);
      @(posedge clk);
      #1;
      check("acc", acc, e.acc);
      check("flags", flags, e.flags);
      check("pc", pc, e.pc);
    end
  endtask

  initial begin
    int extra;
    for (int i = 0; i < 256; i++) mem_h[i] = 8'h00;
    mem_h[0] = 8'h90;

    // LDI 05; ADD [10]=FB; HLT
    start_prog();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h05; mem[8'h02] = 8'h40; mem[8'h03] = 8'h10;
    mem[8'h04] = 8'hF0; mem[8'h10] = 8'hFB;
    push(8'h05, 2'b00, 8'h02, 5);
    push(8'h00, 2'b11, 8'h04, 6);
    push(8'h00, 2'b11, 8'h05, 2);
    @(posedge clk);
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_acc", acc, 8'h00);
    check("rst_flags", flags, 2'b00);
    check("rst_alu_op", alu_op, 3'b010);
    check("rst_we", mem_we, 0);
    check("rst_halted", halted, 0);
    check("rst_retire", retire, 0);
    check("rst_addr", mem_addr, 8'h00);
    reset_i = 1'b0;
    run_retires(3);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (retire) extra++;
    end
    check("halt_no_retire", extra, 0);
    check("halted", halted, 1);
    check("halt_pc", pc, 8'h05);

    // LDI 03; SUB [20]; JZ 40 taken; LDI 07; JZ 60 falls through; HLT
    start_prog();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h03; mem[8'h02] = 8'h50; mem[8'h03] = 8'h20;
    mem[8'h04] = 8'h70; mem[8'h05] = 8'h40; mem[8'h20] = 8'h03;
    mem[8'h40] = 8'h10; mem[8'h41] = 8'h07; mem[8'h42] = 8'h70; mem[8'h43] = 8'h60;
    mem[8'h44] = 8'hF0;
    push(8'h03, 2'b00, 8'h02, 5);
    push(8'h00, 2'b01, 8'h04, 6);
    push(8'h00, 2'b01, 8'h40, 4);
    push(8'h07, 2'b00, 8'h42, 5);
    push(8'h07, 2'b00, 8'h44, 4);
    push(8'h07, 2'b00, 8'h45, 2);
    release_reset();
    run_retires(6);

    // LDI A5; STA 30; HLT
    start_prog();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hA5; mem[8'h02] = 8'h30; mem[8'h03] = 8'h30;
    mem[8'h04] = 8'hF0;
    push(8'hA5, 2'b00, 8'h02, 5);
    push(8'hA5, 2'b00, 8'h04, 5);
    push(8'hA5, 2'b00, 8'h05, 2);
    release_reset();
    run_retires(3);
    check("we_count", we_cnt, 1);
    check("we_addr", we_addr, 8'h30);
    check("we_data", we_data, 8'hA5);
    check("mem30", mem[8'h30], 8'hA5);

    // LDI FF; ADD [20]=02 (carry); LDA [21]=00 keeps fc; JC 50 taken; HLT
    start_prog();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hFF; mem[8'h02] = 8'h40; mem[8'h03] = 8'h20;
    mem[8'h04] = 8'h20; mem[8'h05] = 8'h21; mem[8'h06] = 8'h80; mem[8'h07] = 8'h50;
    mem[8'h20] = 8'h02; mem[8'h21] = 8'h00; mem[8'h50] = 8'hF0;
    push(8'hFF, 2'b00, 8'h02, 5);
    push(8'h01, 2'b10, 8'h04, 6);
    push(8'h00, 2'b11, 8'h06, 6);
    push(8'h00, 2'b11, 8'h50, 4);
    push(8'h00, 2'b11, 8'h51, 2);
    release_reset();
    run_retires(5);

    // JMP FE; LDI 77 at FE/FF wraps PC to 00
    start_prog();
    mem[8'h00] = 8'h60; mem[8'h01] = 8'hFE; mem[8'hFE] = 8'h10; mem[8'hFF] = 8'h77;
    push(8'h00, 2'b00, 8'hFE, 4);
    push(8'h77, 2'b00, 8'h00, 5);
    release_reset();
    run_retires(2);
    @(negedge clk);
    check("wrap_fetch_addr", mem_addr, 8'h00);

    // Undefined opcode 93 runs as a 2-cycle NOP; then HLT
    start_prog();
    mem[8'h00] = 8'h93; mem[8'h01] = 8'hF0;
    push(8'h00, 2'b00, 8'h01, 2);
    push(8'h00, 2'b00, 8'h02, 2);
    release_reset();
    run_retires(2);
    check("illegal_then_halt", halted, 1);

    // Reset during ST drops the write
    start_prog();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hA5; mem[8'h02] = 8'h30; mem[8'h03] = 8'h30;
    push(8'hA5, 2'b00, 8'h02, 5);
    release_reset();
    run_retires(1);
    repeat (5) @(negedge clk);
    check("st_we_pending", mem_we, 1);
    check("st_addr", mem_addr, 8'h30);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("st_rst_we_cnt", we_cnt, 0);
    check("st_rst_mem30", mem[8'h30], 8'h00);
    check("st_rst_we", mem_we, 0);
    check("st_rst_pc", pc, 8'h00);
    check("st_rst_acc", acc, 8'h00);
    check("st_rst_retire", retire, 0);
    check("st_rst_alu_op", alu_op, 3'b010);

    // Reset while halted
    start_prog();
    mem[8'h00] = 8'hF0;
    push(8'h00, 2'b00, 8'h01, 2);
    release_reset();
    run_retires(1);
    @(negedge clk);
    check("pre_rst_halted", halted, 1);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_addr", mem_addr, 8'h00);
    reset_i = 1'b0;

    // Second instance halts on undefined opcode 90 fetched at 00
    repeat (4) @(negedge clk);
    check("illegal_halt_h", halted_h, 1);
    check("illegal_pc_h", pc_h, 8'h01);
    check("illegal_acc_h", acc_h, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multicycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
- Owns PC, IR, operand register (OPR), accumulator (ACC) and flags register.
- Sits directly upstream of the ALU: drives ALU x/y operands and op code, and consumes the ALU result and flags.
- Talks to a single 256-byte program/data memory with 1-cycle synchronous read latency.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- HALT_ON_ILLEGAL, 0, undefined opcode handling: 0 = execute as 1-byte NOP, 1 = enter HALT.

Ports:
- clk_i  in  1  clock; all state changes on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- mem_addr_o  out  8  memory address; read data appears on mem_rdata_i one cycle later.
- mem_rdata_i  in  8  memory read data.
- mem_wdata_o  out  8  write data; always equals ACC.
- mem_we_o  out  1  write strobe; one-cycle pulse.
- alu_x_o  out  8  ALU x operand; always equals ACC.
- alu_y_o  out  8  ALU y operand: OPR during LDI, mem_rdata_i during memory execute, else 0.
- alu_op_o  out  3  ALU op: 000 ADD, 001 SUB, 010 LDA, 111 LDI.
- alu_r_i  in  8  ALU result.
- alu_flags_i  in  2  ALU flags: [0] = fz, [1] = fc.
- acc_o  out  8  ACC register.
- flags_o  out  2  registered flags: [0] = fz, [1] = fc.
- pc_o  out  8  PC register.
- halted_o  out  1  high while in HALT.
- retire_o  out  1  one-cycle pulse in the last cycle of each instruction.

Behaviour:
- Reset values: PC = RESET_PC; ACC, IR, OPR, flags = 0; state = F1; mem_we_o = 0; alu_op_o = 010; halted_o = 0; retire_o = 0.
- Reset is sampled every cycle, including mid-instruction and in HALT, and overrides all other updates (a pending STA write is dropped).
- Instruction format: opcode byte, decoded by bits [7:4] (bits [3:0] ignored), optionally followed by one operand byte.
  - 0 NOP (1 byte)
  - 1 LDI imm
  - 2 LDA addr
  - 3 STA addr
  - 4 ADD addr
  - 5 SUB addr
  - 6 JMP addr
  - 7 JZ addr
  - 8 JC addr
  - F HLT (1 byte)
  - 9-E undefined.
- States:
  - F1: mem_addr_o = PC.
  - F2: IR <= mem_rdata_i; PC <= PC+1. NOP/undefined (HALT_ON_ILLEGAL = 0) -> F1 with retire. HLT/undefined (HALT_ON_ILLEGAL = 1) -> HALT with retire. Otherwise -> A1.
  - A1: mem_addr_o = PC.
  - A2: OPR <= mem_rdata_i; PC <= PC+1. LDI -> EXI. LDA/ADD/SUB -> M1. STA -> ST.
  - A2, jumps: JMP always loads PC <= mem_rdata_i. JZ loads it if flags_o[0] = 1; JC loads it if flags_o[1] = 1. All jumps -> F1 with retire; a taken jump overrides the PC increment.
  - EXI: alu_op_o = 111; alu_y_o = OPR; ACC <= alu_r_i; fz <= alu_flags_i[0]; retire; -> F1.
  - M1: mem_addr_o = OPR.
  - EX: alu_y_o = mem_rdata_i; alu_op_o = 010 (LDA), 000 (ADD) or 001 (SUB). ACC <= alu_r_i; fz <= alu_flags_i[0]. fc <= alu_flags_i[1] for ADD/SUB only; LDA/LDI keep fc. Retire; -> F1.
  - ST: mem_addr_o = OPR; mem_we_o = 1; mem_wdata_o = ACC; retire; -> F1.
  - HALT: no register changes; halted_o = 1; exits only by reset.
- alu_op_o = 010 in every state except EXI and EX.
- mem_addr_o = PC in all states not listed above.
- Latency in cycles: NOP/HLT 2; JMP/JZ/JC 4; LDI 5; STA 5; LDA/ADD/SUB 6.
- PC wraps 8'hFF -> 8'h00 on increment. An operand fetched at address 8'hFF is followed by the opcode fetch at 8'h00.
- ADD/SUB results are modulo 256: fc = carry-out for ADD and borrow for SUB, as produced by the ALU.
- Flags change only in EXI/EX; jumps, STA and NOP leave them unchanged.

Test Plan:
- Reset, then mem[00] = 10 05, mem[02] = 40 10, mem[04] = F0, mem[10] = FB -> ACC = 00, fz = 1, fc = 1, halted_o = 1 with PC = 05; retire_o pulses exactly 3 times.
- LDI 03; SUB from mem[20] = 03 -> ACC = 00, fz = 1, fc = 0. Next JZ 40 -> PC = 40 four cycles after its fetch. Repeat with nonzero ACC -> PC falls through (+2).
- LDI A5; STA 30 -> exactly one mem_we_o cycle with mem_addr_o = 30, mem_wdata_o = A5, 5 cycles after the STA fetch starts.
- fc retention: ADD overflow sets fc = 1, then LDA of 00 -> fz = 1, fc still 1; JC 50 is taken.
- PC wrap: JMP FE with mem[FE] = 10 77 -> ACC = 77, next fetch address 00.
- Reset asserted in ST and in HALT -> next cycle all outputs at reset values, no write issued; opcode 9x with HALT_ON_ILLEGAL = 0 retires in 2 cycles, with HALT_ON_ILLEGAL = 1 -> halted_o = 1.
